png_pixel_sink: RTL and testbench
=================================

// Module: png_pixel_sink
// PURPOSE
// - Downstream of the hard_png decoder: consumes its frame header and pixel stream and
//   normalises every colortype to 32-bit ARGB.
// - Tags each pixel with frame/line position and buffers it in a FIFO behind a
//   valid/ready master port.
// - The decoder has no pixel backpressure, so FIFO overflow drops pixels and is flagged.
// PARAMETERS
// - FIFO_DEPTH   16   output FIFO entries; power of two, >= 4
// - CNT_W        32   width of the y (row) counter; x counter is fixed at 14 bits
// PORTS
// - clk          in   1    single clock, rising edge
// - rstn         in   1    asynchronous active-low reset
// - pix_start    in   1    decoder ostart; 1-cycle pulse, header fields valid same cycle
// - colortype    in   3    0 gray, 1 gray+A, 2 RGB, 3 RGBA, 4 RGB-plte
// - width        in   14   pixels per row
// - height       in   32   rows per frame
// - pix_valid    in   1    decoder ovalid
// - pix_r/g/b/a  in   8    decoder opixelr/g/b/a
// - m_valid      out  1    FIFO head valid
// - m_ready      in   1    downstream accepts the head when m_valid & m_ready
// - m_data       out  32   {A,R,G,B}
// - m_sof        out  1    head is pixel (0,0)
// - m_eol        out  1    head is last pixel of a row
// - m_eof        out  1    head is last pixel of the frame
// - busy         out  1    state == ACTIVE
// - frame_done   out  1    1-cycle pulse when the last pixel of a frame is accepted
// - overflow     out  1    sticky: a pixel was dropped on a full FIFO
// - proto_err    out  1    sticky: zero geometry, pixel in IDLE, or restart mid-frame
// BEHAVIOUR
// - Reset: all outputs 0, FIFO empty, state IDLE, x = y = 0.
// - FSM IDLE: on pix_start latch colortype/width/height and clear overflow and proto_err.
//   - width == 0 or height == 0: set proto_err, stay IDLE.
//   - otherwise: go to ACTIVE.
//   - pix_valid while in IDLE: pixel ignored, proto_err set.
// - FSM ACTIVE: every pix_valid is one pixel.
//   - sof = (x == 0 && y == 0); eol = (x == width-1); eof = eol && (y == height-1).
//   - x increments and wraps to 0 at eol; y increments at eol.
//   - On eof: frame_done pulses, go to IDLE. Only the last pixel arriving in ACTIVE gets eof.
//   - pix_start in ACTIVE: abort the frame; set proto_err after the clear (so it stays set),
//     re-latch the header, x = y = 0. Entries already in the FIFO are not flushed.
//     With zero geometry go to IDLE, otherwise stay in ACTIVE.
//   - pix_start and pix_valid in the same cycle: the header is applied first; the pixel is
//     pixel (0,0) of the new frame.
// - Colour mapping, using the colortype latched at start:
//   - types 0, 1: R = G = B = pix_r.
//   - types 2, 3, 4: R, G, B pass through.
//   - A = pix_a for types 1 and 3, else 8'hFF. Types 5-7 are handled as type 2.
// - FIFO:
//   - Write on an accepted pixel; m_data/flags are visible on the cycle after the write edge
//     (latency 1 when empty).
//   - Full with pop in the same cycle: write allowed. Full without pop: pixel dropped,
//     overflow set, x/y still advance so geometry stays aligned.
//   - Empty with a write: m_valid rises next cycle. No same-cycle bypass.
//   - m_data and flags hold stable while m_valid & !m_ready.
// - Reset mid-frame: FIFO discarded, all state cleared immediately (asynchronous).
// CONFIGURATION
// - PIX_CHECKSUM_EN defined: adds out frame_sum[31:0] and out frame_sum_valid.
//   - frame_sum is the wrapping 32-bit sum of every ARGB word accepted in the frame,
//     dropped words included.
//   - Cleared at pix_start. Published with a 1-cycle frame_sum_valid together with
//     frame_done; frame_sum holds its value until the next frame_done.
// - PIX_CHECKSUM_EN undefined: the ports and the adder are absent.
// STRUCTURE
// - Package png_sink_pkg:
//   - CT_GRAY/CT_GRAYA/CT_RGB/CT_RGBA/CT_PLTE localparams.
//   - FSM state encoding (IDLE, ACTIVE).
//   - FIFO entry width (35 = data + sof + eol + eof).
// - Sub-module png_sink_fifo: synchronous FIFO with DEPTH and WIDTH parameters,
//   wr/rd/full/empty, and write-when-full-with-read support.
// TESTING
// - RGBA 3x2 frame, m_ready = 1: 6 words; sof on word 0; eol on words 2 and 5; eof on
//   word 5 only; frame_done pulses once; pixel (1,2,3,4) -> m_data 32'h04010203.
// - Gray 2x1 with pix_r = 8'h80: m_data 32'hFF808080 twice; alpha forced to FF.
// - m_ready = 0, RGB 1x20 frame, FIFO_DEPTH 16: 16 words kept; overflow set; eof entry
//   dropped; frame_done still pulses; draining returns the first 16 pixels in order.
// - pix_start after 3 of 8 pixels: proto_err set; next 8 pixels form a full new frame
//   with sof on the first of them.
// - Zero width (pix_start, width = 0): proto_err set, busy stays 0, later pix_valid ignored.
// - rstn low mid-frame with a full FIFO: m_valid = 0 and busy = 0 immediately; a clean
//   frame works after release. With PIX_CHECKSUM_EN: 2x1 frame {1, 2} -> frame_sum = 3.

Source files
------------

// File: rtl/png_sink_pkg.sv
// rtl/png_sink_pkg.sv - shared types, colortype codes and ARGB mapping for the PNG pixel sink
package png_sink_pkg;

  // Decoder colortype codes
  localparam logic [2:0] CT_GRAY  = 3'd0;
  localparam logic [2:0] CT_GRAYA = 3'd1;
  localparam logic [2:0] CT_RGB   = 3'd2;
  localparam logic [2:0] CT_RGBA  = 3'd3;
  localparam logic [2:0] CT_PLTE  = 3'd4;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  // FIFO entry: 32-bit ARGB word plus sof/eol/eof tags
  localparam int ENTRY_W = 35;

  typedef struct packed {
    logic [31:0] data;
    logic        sof;
    logic        eol;
    logic        eof;
  } entry_t;

  // Normalise any colortype to {A,R,G,B}; unknown codes (5-7) behave like RGB
  function automatic logic [31:0] map_argb(input logic [2:0] ct,
                                           input logic [7:0] r,
                                           input logic [7:0] g,
                                           input logic [7:0] b,
                                           input logic [7:0] a);
    logic [7:0] ro, go, bo, ao;
    ro = r;
    go = g;
    bo = b;
    ao = 8'hFF;
    if (ct == CT_GRAY || ct == CT_GRAYA) begin
      go = r;
      bo = r;
    end
    if (ct == CT_GRAYA || ct == CT_RGBA) begin
      ao = a;
    end
    return {ao, ro, go, bo};
  endfunction

endpackage

// File: rtl/png_sink_fifo.sv
// rtl/png_sink_fifo.sv - synchronous FIFO with write-when-full-with-read support
module png_sink_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 35
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             wr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_rd;
  logic             do_wr;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

  // A pop frees the slot the same cycle, so a full FIFO still takes a write alongside a read
  assign do_rd = rd && !empty;
  assign do_wr = wr && (!full || do_rd);

  // Storage, pointers and occupancy; memory is cleared so the head reads 0 out of reset
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/png_pixel_sink.sv
// rtl/png_pixel_sink.sv - ARGB-normalising, position-tagging pixel sink behind a valid/ready FIFO; optional PIX_CHECKSUM_EN adds a per-frame word sum
module png_pixel_sink
  import png_sink_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 32
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        pix_start,
  input  logic [2:0]  colortype,
  input  logic [13:0] width,
  input  logic [31:0] height,
  input  logic        pix_valid,
  input  logic [7:0]  pix_r,
  input  logic [7:0]  pix_g,
  input  logic [7:0]  pix_b,
  input  logic [7:0]  pix_a,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] m_data,
  output logic        m_sof,
  output logic        m_eol,
  output logic        m_eof,
  output logic        busy,
  output logic        frame_done,
  output logic        overflow,
  output logic        proto_err
`ifdef PIX_CHECKSUM_EN
  ,
  output logic [31:0] frame_sum,
  output logic        frame_sum_valid
`endif
);

  state_t             state;
  logic [2:0]         ct_q;
  logic [13:0]        wid_q;
  logic [31:0]        hgt_q;
  logic [13:0]        x_q;
  logic [CNT_W-1:0]   y_q;

  logic [2:0]         eff_ct;
  logic [13:0]        eff_w;
  logic [31:0]        eff_h;
  logic [13:0]        eff_x;
  logic [CNT_W-1:0]   eff_y;
  logic               geom_ok;
  logic               take;
  logic               is_sof;
  logic               is_eol;
  logic               is_eof;
  logic [31:0]        argb;
  entry_t             wr_entry;
  entry_t             head;
  logic [ENTRY_W-1:0] head_raw;
  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_rd;

  // A start in the same cycle as a pixel applies the new header to that pixel
  always_comb begin
    eff_ct  = pix_start ? colortype : ct_q;
    eff_w   = pix_start ? width     : wid_q;
    eff_h   = pix_start ? height    : hgt_q;
    eff_x   = pix_start ? '0        : x_q;
    eff_y   = pix_start ? '0        : y_q;
    geom_ok = (width != 14'd0) && (height != 32'd0);
    take    = pix_valid && (pix_start ? geom_ok : (state == ACTIVE));
    is_sof  = (eff_x == 14'd0) && (eff_y == '0);
    is_eol  = (eff_x == eff_w - 14'd1);
    is_eof  = is_eol && (32'(eff_y) == eff_h - 32'd1);
    argb    = map_argb(eff_ct, pix_r, pix_g, pix_b, pix_a);
    wr_entry.data = argb;
    wr_entry.sof  = is_sof;
    wr_entry.eol  = is_eol;
    wr_entry.eof  = is_eof;
  end

  assign fifo_rd = m_valid && m_ready;

  png_sink_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .wr      (take),
    .wr_data (wr_entry),
    .rd      (fifo_rd),
    .rd_data (head_raw),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign head    = entry_t'(head_raw);
  assign m_valid = !fifo_empty;
  assign m_data  = head.data;
  assign m_sof   = head.sof;
  assign m_eol   = head.eol;
  assign m_eof   = head.eof;
  assign busy    = (state == ACTIVE);

  // Frame FSM: header latch, x/y tracking, sticky error/overflow flags and frame_done pulse
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      ct_q       <= '0;
      wid_q      <= '0;
      hgt_q      <= '0;
      x_q        <= '0;
      y_q        <= '0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
      proto_err  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (pix_start) begin
        ct_q      <= colortype;
        wid_q     <= width;
        hgt_q     <= height;
        x_q       <= '0;
        y_q       <= '0;
        overflow  <= 1'b0;
        // Restarting an active frame is itself an error, so it survives the clear
        proto_err <= (state == ACTIVE) || !geom_ok;
        state     <= geom_ok ? ACTIVE : IDLE;
      end else if (pix_valid && state == IDLE) begin
        proto_err <= 1'b1;
      end
      if (take) begin
        // Dropped pixels still advance x/y so later tags stay on the right position
        if (fifo_full && !fifo_rd) begin
          overflow <= 1'b1;
        end
        if (is_eof) begin
          frame_done <= 1'b1;
          state      <= IDLE;
          x_q        <= '0;
          y_q        <= '0;
        end else if (is_eol) begin
          x_q <= '0;
          y_q <= eff_y + CNT_W'(1);
        end else begin
          x_q <= eff_x + 14'd1;
          y_q <= eff_y;
        end
      end
    end
  end

`ifdef PIX_CHECKSUM_EN
  logic [31:0] sum_acc;
  logic [31:0] sum_next;

  assign sum_next = (pix_start ? 32'd0 : sum_acc) + argb;

  // Running sum of every taken word, dropped ones included, published at end of frame
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sum_acc         <= '0;
      frame_sum       <= '0;
      frame_sum_valid <= 1'b0;
    end else begin
      frame_sum_valid <= 1'b0;
      if (take) begin
        sum_acc <= sum_next;
      end else if (pix_start) begin
        sum_acc <= '0;
      end
      if (take && is_eof) begin
        frame_sum       <= sum_next;
        frame_sum_valid <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_png_pixel_sink.sv
// tb/tb_png_pixel_sink.sv - table-driven and directed-sequence bench for png_pixel_sink
module tb_png_pixel_sink;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        pix_start = 1'b0;
  logic [2:0]  colortype = '0;
  logic [13:0] width = '0;
  logic [31:0] height = '0;
  logic        pix_valid = 1'b0;
  logic [7:0]  pix_r = '0, pix_g = '0, pix_b = '0, pix_a = '0;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic [31:0] m_data;
  logic        m_sof, m_eol, m_eof, busy, frame_done, overflow, proto_err;
`ifdef PIX_CHECKSUM_EN
  logic [31:0] frame_sum;
  logic        frame_sum_valid;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  png_pixel_sink #(.FIFO_DEPTH(16), .CNT_W(32)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .pix_start  (pix_start),
    .colortype  (colortype),
    .width      (width),
    .height     (height),
    .pix_valid  (pix_valid),
    .pix_r      (pix_r),
    .pix_g      (pix_g),
    .pix_b      (pix_b),
    .pix_a      (pix_a),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_sof      (m_sof),
    .m_eol      (m_eol),
    .m_eof      (m_eof),
    .busy       (busy),
    .frame_done (frame_done),
    .overflow   (overflow),
    .proto_err  (proto_err)
`ifdef PIX_CHECKSUM_EN
    ,
    .frame_sum       (frame_sum),
    .frame_sum_valid (frame_sum_valid)
`endif
  );

  typedef struct {
    logic        st;
    logic [2:0]  ct;
    logic [13:0] w;
    logic [31:0] h;
    logic        v;
    logic [7:0]  r, g, b, a;
    logic        mv;
    logic [31:0] data;
    logic        sof, eol, eof, fd, bsy;
  } vec_t;

  vec_t vecs [14];

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present one cycle of decoder inputs; returns #1 after the capturing edge
  task automatic drive(input logic st, input logic [2:0] ct, input logic [13:0] w,
                       input logic [31:0] h, input logic v, input logic [7:0] r,
                       input logic [7:0] g, input logic [7:0] b, input logic [7:0] a);
    @(negedge clk);
    pix_start = st;
    colortype = ct;
    width     = w;
    height    = h;
    pix_valid = v;
    pix_r = r; pix_g = g; pix_b = b; pix_a = a;
    @(posedge clk);
    #1;
    pix_start = 1'b0;
    pix_valid = 1'b0;
  endtask

  initial begin
    //          st ct  w  h  v  r      g      b      a      mv data          sof eol eof fd bsy
    vecs[0]  = '{1, 3, 3, 2, 1, 8'h01, 8'h02, 8'h03, 8'h04, 1, 32'h04010203, 1, 0, 0, 0, 1};
    vecs[1]  = '{0, 3, 3, 2, 1, 8'h11, 8'h21, 8'h31, 8'h41, 1, 32'h41112131, 0, 0, 0, 0, 1};
    vecs[2]  = '{0, 3, 3, 2, 1, 8'h12, 8'h22, 8'h32, 8'h42, 1, 32'h42122232, 0, 1, 0, 0, 1};
    vecs[3]  = '{0, 3, 3, 2, 1, 8'h13, 8'h23, 8'h33, 8'h43, 1, 32'h43132333, 0, 0, 0, 0, 1};
    vecs[4]  = '{0, 3, 3, 2, 1, 8'h14, 8'h24, 8'h34, 8'h44, 1, 32'h44142434, 0, 0, 0, 0, 1};
    vecs[5]  = '{0, 3, 3, 2, 1, 8'h15, 8'h25, 8'h35, 8'h45, 1, 32'h45152535, 0, 1, 1, 1, 0};
    vecs[6]  = '{0, 3, 3, 2, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 32'h00000000, 0, 0, 0, 0, 0};
    vecs[7]  = '{1, 0, 2, 1, 1, 8'h80, 8'h11, 8'h22, 8'h33, 1, 32'hFF808080, 1, 0, 0, 0, 1};
    vecs[8]  = '{0, 0, 2, 1, 1, 8'h80, 8'h44, 8'h55, 8'h66, 1, 32'hFF808080, 0, 1, 1, 1, 0};
    vecs[9]  = '{1, 1, 1, 1, 1, 8'h05, 8'h06, 8'h07, 8'h09, 1, 32'h09050505, 1, 1, 1, 1, 0};
    vecs[10] = '{1, 6, 1, 1, 1, 8'h01, 8'h02, 8'h03, 8'h77, 1, 32'hFF010203, 1, 1, 1, 1, 0};
    vecs[11] = '{1, 4, 1, 1, 1, 8'h0A, 8'h0B, 8'h0C, 8'h99, 1, 32'hFF0A0B0C, 1, 1, 1, 1, 0};
    vecs[12] = '{1, 7, 1, 1, 1, 8'h20, 8'h30, 8'h40, 8'h12, 1, 32'hFF203040, 1, 1, 1, 1, 0};
    vecs[13] = '{0, 0, 1, 1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 32'h00000000, 0, 0, 0, 0, 0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk1("rst m_valid", m_valid, 1'b0);
    chk32("rst m_data", m_data, 32'h0);
    chk1("rst m_sof", m_sof, 1'b0);
    chk1("rst m_eof", m_eof, 1'b0);
    chk1("rst busy", busy, 1'b0);
    chk1("rst frame_done", frame_done, 1'b0);
    chk1("rst overflow", overflow, 1'b0);
    chk1("rst proto_err", proto_err, 1'b0);
    @(negedge clk);
    rstn = 1'b1;

    // Table: RGBA 3x2, gray 2x1, single-pixel colortype mapping
    m_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].st, vecs[i].ct, vecs[i].w, vecs[i].h, vecs[i].v,
            vecs[i].r, vecs[i].g, vecs[i].b, vecs[i].a);
      chk1($sformatf("vec%0d m_valid", i), m_valid, vecs[i].mv);
      if (vecs[i].mv) begin
        chk32($sformatf("vec%0d m_data", i), m_data, vecs[i].data);
        chk1($sformatf("vec%0d m_sof", i), m_sof, vecs[i].sof);
        chk1($sformatf("vec%0d m_eol", i), m_eol, vecs[i].eol);
        chk1($sformatf("vec%0d m_eof", i), m_eof, vecs[i].eof);
      end
      chk1($sformatf("vec%0d frame_done", i), frame_done, vecs[i].fd);
      chk1($sformatf("vec%0d busy", i), busy, vecs[i].bsy);
      chk1($sformatf("vec%0d proto_err", i), proto_err, 1'b0);
    end

    // Restart after 3 of 8 pixels
    for (int i = 0; i < 3; i++) begin
      drive(i == 0, 3'd2, 14'd8, 32'd1, 1'b1, 8'(i), 8'h00, 8'h00, 8'h00);
    end
    chk1("restart pre proto_err", proto_err, 1'b0);
    drive(1'b1, 3'd2, 14'd8, 32'd1, 1'b1, 8'hA0, 8'hB0, 8'hC0, 8'h00);
    chk1("restart proto_err", proto_err, 1'b1);
    chk1("restart sof", m_sof, 1'b1);
    chk32("restart data", m_data, 32'hFFA0B0C0);
    chk1("restart busy", busy, 1'b1);
    for (int i = 1; i < 8; i++) begin
      drive(1'b0, 3'd2, 14'd8, 32'd1, 1'b1, 8'hA0 + 8'(i), 8'hB0, 8'hC0, 8'h00);
      chk1($sformatf("restart px%0d sof", i), m_sof, 1'b0);
      chk1($sformatf("restart px%0d eof", i), m_eof, i == 7);
      chk1($sformatf("restart px%0d frame_done", i), frame_done, i == 7);
    end
    chk1("restart end busy", busy, 1'b0);
    chk1("restart sticky proto_err", proto_err, 1'b1);
    drive(1'b1, 3'd2, 14'd1, 32'd1, 1'b1, 8'h01, 8'h02, 8'h03, 8'h00);
    chk1("clean start clears proto_err", proto_err, 1'b0);
    chk1("clean start eof", m_eof, 1'b1);

    // Zero width
    drive(1'b1, 3'd2, 14'd0, 32'd5, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
    chk1("zero width proto_err", proto_err, 1'b1);
    chk1("zero width busy", busy, 1'b0);
    drive(1'b0, 3'd2, 14'd0, 32'd5, 1'b1, 8'h55, 8'h55, 8'h55, 8'h00);
    chk1("zero width pixel ignored", m_valid, 1'b0);
    chk1("zero width busy later", busy, 1'b0);

    // Overflow: RGB 1x20 with no drain
    m_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      drive(i == 0, 3'd2, 14'd1, 32'd20, 1'b1, 8'(i), 8'h40 + 8'(i), 8'h80 + 8'(i), 8'h00);
      if (i == 0) chk1("ovf start clears proto_err", proto_err, 1'b0);
      if (i == 15) chk1("ovf not yet at 16", overflow, 1'b0);
      if (i == 16) chk1("ovf set at 17", overflow, 1'b1);
    end
    chk1("ovf frame_done", frame_done, 1'b1);
    chk1("ovf busy", busy, 1'b0);
    m_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk1($sformatf("drain%0d m_valid", i), m_valid, 1'b1);
      chk32($sformatf("drain%0d m_data", i), m_data, {8'hFF, 8'(i), 8'h40 + 8'(i), 8'h80 + 8'(i)});
      chk1($sformatf("drain%0d m_sof", i), m_sof, i == 0);
      chk1($sformatf("drain%0d m_eol", i), m_eol, 1'b1);
      chk1($sformatf("drain%0d m_eof", i), m_eof, 1'b0);
      @(posedge clk);
      #1;
    end
    chk1("drain empty", m_valid, 1'b0);
    chk1("ovf sticky", overflow, 1'b1);

    // Reset mid-frame with a full FIFO
    m_ready = 1'b0;
    for (int i = 0; i < 18; i++) begin
      drive(i == 0, 3'd2, 14'd4, 32'd8, 1'b1, 8'(i), 8'h00, 8'h00, 8'h00);
    end
    chk1("pre-reset overflow", overflow, 1'b1);
    chk1("pre-reset busy", busy, 1'b1);
    @(posedge clk);
    #3;
    rstn = 1'b0;
    #1;
    chk1("async rst m_valid", m_valid, 1'b0);
    chk1("async rst busy", busy, 1'b0);
    chk1("async rst overflow", overflow, 1'b0);
    @(negedge clk);
    rstn = 1'b1;
    m_ready = 1'b1;
    drive(1'b1, 3'd3, 14'd2, 32'd1, 1'b1, 8'h00, 8'h00, 8'h01, 8'h00);
    chk32("post-reset word0", m_data, 32'h00000001);
    chk1("post-reset sof", m_sof, 1'b1);
    drive(1'b0, 3'd3, 14'd2, 32'd1, 1'b1, 8'h00, 8'h00, 8'h02, 8'h00);
    chk32("post-reset word1", m_data, 32'h00000002);
    chk1("post-reset eof", m_eof, 1'b1);
    chk1("post-reset frame_done", frame_done, 1'b1);
`ifdef PIX_CHECKSUM_EN
    chk1("frame_sum_valid", frame_sum_valid, 1'b1);
    chk32("frame_sum", frame_sum, 32'd3);
    @(posedge clk);
    #1;
    chk1("frame_sum_valid pulse", frame_sum_valid, 1'b0);
    chk32("frame_sum hold", frame_sum, 32'd3);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
